// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller: state encoding, counter width
// and default run parameters.
// Latency: none (definitions only). Backpressure: none.
package bist_pkg;

  localparam int N_PATTERNS_DEF = 255;
  localparam int FLUSH_CYC_DEF  = 2;
  localparam int SIG_W_DEF      = 16;
  localparam int CNT_W          = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] COMPARE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = IDLE,
    ST_INIT    = INIT,
    ST_RUN     = RUN,
    ST_FLUSH   = FLUSH,
    ST_COMPARE = COMPARE,
    ST_DONE    = DONE
  } state_t;

endpackage

// File: rtl/bist_cnt.sv
// Pattern / flush cycle counter with synchronous clear and terminal-count flag.
// Latency: tc is combinational from the registered count.
// Backpressure: none; counts whenever en is high, clr has priority.
// Ports: CLK/RST clock and async active-low reset; clr, en control;
//        tc_val terminal value; tc high while the count equals tc_val.
module bist_cnt
  import bist_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/bist_ctrl.sv
// Logic BIST sequencer: drives external LFSR/MISR control and checks the signature.
// Latency: bist_end rises 3 + N_PATTERNS + FLUSH_CYC cycles after the start edge.
// Backpressure: none; start edges are ignored while a run is in progress.
// Ports: CLK/RST clock and async active-low reset; bist_start run request
//        (rising edge); misr_sig current signature; Moore control outputs
//        bist_mode, lfsr_init/en, misr_init/en, busy, bist_end, pass_fail.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int               N_PATTERNS = N_PATTERNS_DEF,
  parameter int               FLUSH_CYC  = FLUSH_CYC_DEF,
  parameter int               SIG_W      = SIG_W_DEF,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bist_start,
  input  logic [SIG_W-1:0] misr_sig,
  output logic             bist_mode,
  output logic             lfsr_init,
  output logic             lfsr_en,
  output logic             misr_init,
  output logic             misr_en,
  output logic             busy,
  output logic             bist_end,
  output logic             pass_fail
);

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = (FLUSH_CYC == 0) ? '0 : CNT_W'(FLUSH_CYC - 1);

  state_t state_q, state_d;
  logic   start_q, start_d;
  // arm_q marks that start_q holds a real post-reset sample, so a request
  // already high when reset releases is not mistaken for a rising edge.
  logic   arm_q, arm_d;
  logic   pass_q, pass_d;
  logic   start_pulse;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_tc_val;

  assign start_pulse = bist_start & ~start_q & arm_q;
  assign start_d     = bist_start;
  assign arm_d       = 1'b1;

  bist_cnt #(.W(CNT_W)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (cnt_tc_val),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_tc_val = RUN_LAST;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_pulse) begin
          state_d = ST_INIT;
          pass_d  = 1'b0;
        end
      end
      ST_INIT: begin
        cnt_clr = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          // Restart the count so FLUSH can reuse it from zero.
          cnt_clr = 1'b1;
          state_d = (FLUSH_CYC == 0) ? ST_COMPARE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_en     = 1'b1;
        cnt_tc_val = FLUSH_LAST;
        if (cnt_tc) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        pass_d  = (misr_sig == GOLDEN_SIG);
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bist_mode = 1'b0;
    lfsr_init = 1'b0;
    lfsr_en   = 1'b0;
    misr_init = 1'b0;
    misr_en   = 1'b0;
    busy      = 1'b0;
    bist_end  = 1'b0;
    case (state_q)
      ST_INIT: begin
        bist_mode = 1'b1;
        lfsr_init = 1'b1;
        misr_init = 1'b1;
        busy      = 1'b1;
      end
      ST_RUN: begin
        bist_mode = 1'b1;
        lfsr_en   = 1'b1;
        misr_en   = 1'b1;
        busy      = 1'b1;
      end
      ST_FLUSH: begin
        bist_mode = 1'b1;
        misr_en   = 1'b1;
        busy      = 1'b1;
      end
      ST_COMPARE: begin
        bist_mode = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        bist_end = 1'b1;
      end
      default: begin
        bist_mode = 1'b0;
      end
    endcase
  end

  assign pass_fail = pass_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      arm_q   <= arm_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Testbench for bist_ctrl: two instances (8 patterns / 2 flush, 1 pattern / 0 flush)
// checked every cycle against a timeline model, plus directed run checks.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_bist_ctrl;

  logic        CLK;
  logic        RST;
  logic [1:0]  bist_start;
  logic [15:0] misr_sig [2];
  logic [7:0]  outs [2];  // {mode, lfsr_init, lfsr_en, misr_init, misr_en, busy, end, pass}

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0] V_INIT = 8'b1101_0100;
  localparam logic [7:0] V_RUN  = 8'b1010_1100;
  localparam logic [7:0] V_FLSH = 8'b1000_1100;
  localparam logic [7:0] V_CMP  = 8'b1000_0100;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic bm, li, le, mi, me, bz, be, pf;
    bist_ctrl #(
      .N_PATTERNS (g == 0 ? 8 : 1),
      .FLUSH_CYC  (g == 0 ? 2 : 0),
      .SIG_W      (16),
      .GOLDEN_SIG (g == 0 ? 16'hA5C3 : 16'h3C5A)
    ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bist_start (bist_start[g]),
      .misr_sig   (misr_sig[g]),
      .bist_mode  (bm),
      .lfsr_init  (li),
      .lfsr_en    (le),
      .misr_init  (mi),
      .misr_en    (me),
      .busy       (bz),
      .bist_end   (be),
      .pass_fail  (pf)
    );
    assign outs[g] = {bm, li, le, mi, me, bz, be, pf};
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int np_of(input int k);
    return (k == 0) ? 8 : 1;
  endfunction
  function automatic int fc_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction
  function automatic logic [15:0] gold_of(input int k);
    return (k == 0) ? 16'hA5C3 : 16'h3C5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline of t = 1 .. NP+FC+2 cycles after
  // the start edge (INIT, NP run cycles, FC flush cycles, compare), then DONE.
  bit m_active [2] = '{0, 0};
  bit m_done   [2] = '{0, 0};
  bit m_pass   [2] = '{0, 0};
  bit m_prev   [2] = '{0, 0};
  bit m_valid  [2] = '{0, 0};
  int m_t      [2] = '{0, 0};
  bit m_pulse;

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST) begin
        m_active[k] = 0; m_done[k] = 0; m_pass[k] = 0;
        m_prev[k]   = 0; m_valid[k] = 0; m_t[k] = 0;
      end else begin
        m_pulse = m_valid[k] && bist_start[k] && !m_prev[k];
        if (m_active[k]) begin
          if (m_t[k] == np_of(k) + fc_of(k) + 2) begin
            m_pass[k]   = (misr_sig[k] == gold_of(k));
            m_done[k]   = 1;
            m_active[k] = 0;
          end else begin
            m_t[k] = m_t[k] + 1;
          end
        end else if (m_pulse) begin
          m_active[k] = 1; m_t[k] = 1; m_done[k] = 0; m_pass[k] = 0;
        end
        m_prev[k]  = bist_start[k];
        m_valid[k] = 1;
      end
    end
  end

  function automatic logic [7:0] model_exp(input int k);
    int t;
    if (!m_active[k]) return {6'b0, m_done[k], m_pass[k]};
    t = m_t[k];
    if (t == 1) return V_INIT;
    if (t <= np_of(k) + 1) return V_RUN;
    if (t <= np_of(k) + fc_of(k) + 1) return V_FLSH;
    return V_CMP;
  endfunction

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_outs", k), 32'(outs[k]), 32'(RST ? model_exp(k) : 8'h00));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One start pulse on instance k; measures latency and enable-cycle counts.
  task automatic run_once(input int k, input bit bad, input bit hold);
    int cyc, nl, nm;
    misr_sig[k] = bad ? (gold_of(k) ^ 16'h0001) : gold_of(k);
    bist_start[k] = 1'b0;
    tick(2);
    bist_start[k] = 1'b1;
    cyc = 0; nl = 0; nm = 0;
    while (cyc < 60) begin
      tick(1);
      if (!hold) bist_start[k] = 1'b0;
      @(negedge CLK);
      cyc++;
      if (cyc == 1) chk($sformatf("dut%0d_init_cycle", k), 32'(outs[k]), 32'(V_INIT));
      if (outs[k][5]) nl++;
      if (outs[k][3]) nm++;
      if (outs[k][1]) break;
    end
    chk($sformatf("dut%0d_latency", k), 32'(cyc), 32'(np_of(k) + fc_of(k) + 3));
    chk($sformatf("dut%0d_lfsr_en_cycles", k), 32'(nl), 32'(np_of(k)));
    chk($sformatf("dut%0d_misr_en_cycles", k), 32'(nm), 32'(np_of(k) + fc_of(k)));
    chk($sformatf("dut%0d_pass_fail", k), 32'(outs[k][0]), 32'(!bad));
  endtask

  initial begin
    RST = 1'b0;
    bist_start = 2'b00;
    misr_sig[0] = gold_of(0);
    misr_sig[1] = gold_of(1);
    tick(3);

    // Request already high when reset releases must not start a run.
    bist_start[0] = 1'b1;
    tick(1);
    RST = 1'b1;
    tick(5);
    @(negedge CLK);
    chk("no_start_at_release_busy", 32'(outs[0][2]), 32'(0));
    bist_start[0] = 1'b0;

    run_once(0, 1'b0, 1'b0);
    run_once(0, 1'b1, 1'b0);
    run_once(1, 1'b0, 1'b0);

    // Held request: one run only, then DONE persists until a fresh edge.
    run_once(0, 1'b0, 1'b1);
    tick(8);
    @(negedge CLK);
    chk("held_stays_done", 32'(outs[0]), 32'(8'b0000_0011));
    bist_start[0] = 1'b0;
    tick(3);
    @(negedge CLK);
    chk("dropped_stays_done", 32'(outs[0]), 32'(8'b0000_0011));
    run_once(0, 1'b0, 1'b0);

    // Reset during RUN with count 4, request held high afterwards.
    bist_start[0] = 1'b0;
    tick(2);
    bist_start[0] = 1'b1;
    tick(6);
    #1;
    chk("pre_reset_run", 32'(outs[0]), 32'(V_RUN));
    #1;
    RST = 1'b0;
    #1;
    chk("async_reset_dut0", 32'(outs[0]), 32'(0));
    chk("async_reset_dut1", 32'(outs[1]), 32'(0));
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick(10);
    @(negedge CLK);
    chk("idle_after_reset_held", 32'(outs[0]), 32'(0));
    bist_start[0] = 1'b0;
    run_once(1, 1'b1, 1'b0);

    // Random request, signature and reset traffic against the model.
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (!RST) RST = 1'b1;
      else if ($urandom_range(0, 299) == 0) RST = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 5) == 0) bist_start[k] = ~bist_start[k];
        misr_sig[k] = ($urandom_range(0, 1) == 1) ? gold_of(k) : 16'($urandom);
      end
    end
    RST = 1'b1;
    tick(2);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
